bp_table: RTL and testbench

- Direct-mapped, tagged branch history table holding the core's 2-bit saturating prediction counters.
- Read side: the fetch stage looks up the fetch PC and receives a registered taken/not-taken guess one cycle later, aligned with decode.
- Write side: the execute stage reports each resolved branch. The table allocates the entry or applies the saturating counter update, using the core-wide counter encoding.

---
 rtl/bp_table.sv | 124 ++++++++++++
 tb/tb_bp_table.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bp_table.sv
// bp_table: direct-mapped, tagged table of 2-bit saturating branch
// prediction counters. The fetch side gets a registered guess one cycle after
// lookup. The execute side allocates an entry or updates its counter for each
// resolved branch.
module bp_table #(
    parameter int PC_WIDTH = 32,
    parameter int LINES    = 32,
    parameter int IDX_BITS = $clog2(LINES),
    parameter int TAG_BITS = PC_WIDTH - IDX_BITS - 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic [PC_WIDTH-1:0] pc_guess,
    input  logic                is_br_guess,
    output logic                br_pred_taken,
    output logic                br_pred_hit,
    input  logic [PC_WIDTH-1:0] pc_check,
    input  logic                is_br_check,
    input  logic                br_taken_check
);

    // Core-wide counter encoding; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        CTR_WNT = 2'b00,
        CTR_SNT = 2'b01,
        CTR_ST  = 2'b10,
        CTR_WT  = 2'b11
    } ctr_e;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q [LINES];
    ctr_e                ctr_q [LINES];

    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0] wr_tag;
    logic [IDX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0] rd_tag;

    logic                wr_hit;
    ctr_e                wr_ctr;

    logic                collide;
    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_entry_tag;
    ctr_e                rd_ctr;
    logic                hit_next;
    logic                taken_next;

    // Byte-offset bits of the PCs are not used for indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc_guess[1:0], pc_check[1:0]};

    assign wr_idx = pc_check[IDX_BITS+1:2];
    assign wr_tag = pc_check[PC_WIDTH-1:IDX_BITS+2];
    assign rd_idx = pc_guess[IDX_BITS+1:2];
    assign rd_tag = pc_guess[PC_WIDTH-1:IDX_BITS+2];

    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        ctr_e n;
        n = c;
        case (c)
            CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
            CTR_WT:  n = taken ? CTR_ST  : CTR_SNT;
            CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: n = taken ? CTR_ST  : CTR_SNT;
            default: n = c;
        endcase
        return n;
    endfunction

    // Counter value the update port will write: step on hit, fresh weak state on miss.
    always_comb begin
        wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        wr_ctr = br_taken_check ? CTR_WT : CTR_WNT;
        if (wr_hit) begin
            wr_ctr = ctr_next(ctr_q[wr_idx], br_taken_check);
        end
    end

    // Lookup with write-first bypass so a same-index update is already visible.
    always_comb begin
        collide      = is_br_check && (wr_idx == rd_idx);
        rd_valid     = valid_q[rd_idx];
        rd_entry_tag = tag_q[rd_idx];
        rd_ctr       = ctr_q[rd_idx];
        if (collide) begin
            rd_valid     = 1'b1;
            rd_entry_tag = wr_tag;
            rd_ctr       = wr_ctr;
        end
        hit_next   = is_br_guess && rd_valid && (rd_entry_tag == rd_tag);
        taken_next = hit_next && rd_ctr[1];
    end

    // Valid bits: cleared by reset, set on every update (allocation or hit).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (is_br_check) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and counter storage; unreset because valid gates every use.
    always_ff @(posedge clk) begin
        if (is_br_check) begin
            tag_q[wr_idx] <= wr_tag;
            ctr_q[wr_idx] <= wr_ctr;
        end
    end

    // Prediction output register, frozen while fetch is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_pred_hit   <= 1'b0;
            br_pred_taken <= 1'b0;
        end else if (!stall) begin
            br_pred_hit   <= hit_next;
            br_pred_taken <= taken_next;
        end
    end

endmodule

// File: tb/tb_bp_table.sv
// tb_bp_table: directed test-plan sequence with literal expectations, then
// randomized traffic compared every cycle against a behavioural table model.
module tb_bp_table;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [31:0] pc_guess;
    logic        is_br_guess;
    logic        br_pred_taken;
    logic        br_pred_hit;
    logic [31:0] pc_check;
    logic        is_br_check;
    logic        br_taken_check;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Behavioural model: 32 lines, counters as integers 0..3 (bit 1 = taken).
    int m_valid [32];
    int m_tag   [32];
    int m_ctr   [32];
    int up_tbl  [4] = '{2, 0, 2, 2};
    int dn_tbl  [4] = '{1, 1, 3, 1};
    logic exp_hit;
    logic exp_taken;

    bp_table #(.PC_WIDTH(32), .LINES(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .pc_guess       (pc_guess),
        .is_br_guess    (is_br_guess),
        .br_pred_taken  (br_pred_taken),
        .br_pred_hit    (br_pred_hit),
        .pc_check       (pc_check),
        .is_br_check    (is_br_check),
        .br_taken_check (br_taken_check)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: apply the resolved branch first, then look up, which gives write-first.
    always @(posedge clk or negedge rst_n) begin
        int wi, wt, ri, rt;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_valid[i] = 0;
            exp_hit   = 1'b0;
            exp_taken = 1'b0;
        end else begin
            if (is_br_check) begin
                wi = int'((pc_check >> 2) % 32);
                wt = int'(pc_check >> 7);
                if (m_valid[wi] != 0 && m_tag[wi] == wt) begin
                    m_ctr[wi] = br_taken_check ? up_tbl[m_ctr[wi]] : dn_tbl[m_ctr[wi]];
                end else begin
                    m_valid[wi] = 1;
                    m_tag[wi]   = wt;
                    m_ctr[wi]   = br_taken_check ? 3 : 0;
                end
            end
            if (!stall) begin
                ri = int'((pc_guess >> 2) % 32);
                rt = int'(pc_guess >> 7);
                exp_hit   = is_br_guess && m_valid[ri] != 0 && m_tag[ri] == rt;
                exp_taken = exp_hit && m_ctr[ri] >= 2;
            end
        end
    end

    // Compare process: outputs sampled on the falling edge, away from updates.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model.hit", br_pred_hit, exp_hit);
            check("model.taken", br_pred_taken, exp_taken);
        end
    end

    task automatic drive(input logic [31:0] pg, input logic ig, input logic [31:0] pcc,
                         input logic ic, input logic tk, input logic st);
        pc_guess       = pg;
        is_br_guess    = ig;
        pc_check       = pcc;
        is_br_check    = ic;
        br_taken_check = tk;
        stall          = st;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lk(input logic [31:0] pc);
        drive(pc, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic up(input logic [31:0] pc, input logic tk);
        drive(32'h0, 1'b0, pc, 1'b1, tk, 1'b0);
    endtask

    task automatic expect2(input string name, input logic h, input logic t);
        check({name, ".hit"}, br_pred_hit, h);
        check({name, ".taken"}, br_pred_taken, t);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tg, ix, lo;
        tg = $urandom_range(0, 3);
        ix = $urandom_range(0, 31);
        lo = $urandom_range(0, 3);
        return (tg << 7) | (ix << 2) | lo;
    endfunction

    initial begin
        logic [31:0] pg;
        rst_n = 1'b0;
        stall = 1'b0;
        pc_guess = '0;
        is_br_guess = 1'b0;
        pc_check = '0;
        is_br_check = 1'b0;
        br_taken_check = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        lk(32'h0000_1000);        expect2("reset_lookup", 1'b0, 1'b0);

        up(32'h1000, 1'b1);
        lk(32'h1000);             expect2("alloc_taken", 1'b1, 1'b1);
        up(32'h1000, 1'b0);
        up(32'h1000, 1'b0);
        lk(32'h1000);             expect2("two_nt", 1'b1, 1'b0);
        up(32'h1000, 1'b1);
        lk(32'h1000);             expect2("snt_to_wnt", 1'b1, 1'b0);
        up(32'h1000, 1'b1);
        lk(32'h1000);             expect2("wnt_to_st", 1'b1, 1'b1);

        repeat (5) up(32'h2000, 1'b1);
        up(32'h2000, 1'b0);
        lk(32'h2000);             expect2("sat_st_to_wt", 1'b1, 1'b1);
        up(32'h2000, 1'b0);
        lk(32'h2000);             expect2("sat_wt_to_snt", 1'b1, 1'b0);

        up(32'h1000, 1'b1);
        up(32'h1080, 1'b0);
        lk(32'h1000);             expect2("alias_old", 1'b0, 1'b0);
        lk(32'h1080);             expect2("alias_new", 1'b1, 1'b0);

        drive(32'h1000, 1'b1, 32'h1080, 1'b1, 1'b1, 1'b1);  expect2("stall1", 1'b1, 1'b0);
        drive(32'h1200, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);     expect2("stall2", 1'b1, 1'b0);
        drive(32'h1080, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);     expect2("stall3", 1'b1, 1'b0);
        lk(32'h1080);             expect2("post_stall", 1'b1, 1'b1);

        pc_guess = 32'h1080;
        is_br_guess = 1'b1;
        pc_check = 32'h1080;
        is_br_check = 1'b1;
        br_taken_check = 1'b0;
        #2 rst_n = 1'b0;
        #1 expect2("async_reset", 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lk(32'h1080);             expect2("after_reset_a", 1'b0, 1'b0);
        lk(32'h1000);             expect2("after_reset_b", 1'b0, 1'b0);

        drive(32'h3000, 1'b1, 32'h3000, 1'b1, 1'b1, 1'b0);  expect2("collision", 1'b1, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] pcc;
            pg  = rand_pc();
            pcc = ($urandom_range(0, 4) == 0) ? pg : rand_pc();
            drive(pg, ($urandom_range(0, 9) < 7), pcc, ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
